// File: rtl/arbitro_tx.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_tx
// Description : Two-requester round-robin arbiter feeding a byte-serialising
//               transmitter. Time is divided into slots whose length is
//               SYM_CYCLES clocks per payload byte. Arbitration happens only in
//               the terminal-count cycle of a slot. The winner's payload drives
//               the next slot. With no winner, a COMMA (K28.5, 8'hBC) slot is
//               sent instead.
// Revision    : 1.0 - initial release
//
// Parameters  : SYM_CYCLES   - clk cycles per serialised byte
//               SKP_INTERVAL - completed slots between SKP insertions
// Macro       : SKP_INSERT_EN - when defined, a SKP slot (K28.0, 8'h1C) is
//               inserted after every SKP_INTERVAL completed slots.
//
// Ports       : clk            - clock, rising edge
//               rst            - asynchronous reset, active low
//               enb            - global enable; low freezes everything
//               req0/req1      - requester wants a slot
//               data0/data1    - payload (8-bit in [7:0], 16-bit in [15:0])
//               size0/size1    - 00 8b, 01 16b, 10 32b, 11 treated as 00
//               k0/k1          - control-symbol flag
//               gnt0/gnt1      - one-cycle accept pulse in the tc cycle
//               dataIn         - 8-bit transmitter data
//               dataIn16       - 16-bit transmitter data
//               dataIn32       - 32-bit transmitter data
//               dataS          - transmitter size select
//               K              - transmitter control flag
//               busy           - high while a requester payload holds the slot
// ============================================================================
module arbitro_tx #(
  parameter int SYM_CYCLES   = 10,
  parameter int SKP_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic        k0,
  input  logic        k1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  dataIn,
  output logic [15:0] dataIn16,
  output logic [31:0] dataIn32,
  output logic [1:0]  dataS,
  output logic        K,
  output logic        busy
);

  localparam int CW = $clog2(4 * SYM_CYCLES);
  localparam logic [CW-1:0] LEN_8  = CW'(SYM_CYCLES - 1);
  localparam logic [CW-1:0] LEN_16 = CW'(2 * SYM_CYCLES - 1);
  localparam logic [CW-1:0] LEN_32 = CW'(4 * SYM_CYCLES - 1);
  localparam logic [7:0]    COMMA_SYM = 8'hBC;

`ifdef SKP_INSERT_EN
  localparam logic [7:0]    SKP_SYM   = 8'h1C;
  localparam int            SW        = $clog2(SKP_INTERVAL + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SKP_INTERVAL - 1);

  typedef enum logic [1:0] {
    ST_COMMA = 2'd0,
    ST_SEND  = 2'd1,
    ST_SKP   = 2'd2
  } state_t;

  logic [SW-1:0] slot_q, slot_d;
`else
  typedef enum logic [0:0] {
    ST_COMMA = 1'b0,
    ST_SEND  = 1'b1
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;          // 1: req1 wins a tie next time
  logic [1:0]    dataS_q, dataS_d;
  logic [7:0]    dataIn_q, dataIn_d;
  logic [15:0]   dataIn16_q, dataIn16_d;
  logic [31:0]   dataIn32_q, dataIn32_d;
  logic          K_q, K_d;

  logic          tc;
  logic          skp_now;
  logic          win1;
  logic [1:0]    sel_size;
  logic [31:0]   sel_data;
  logic          sel_k;

  assign tc = enb && (cnt_q == '0);

  // --------------------------------------------------------------------------
  // Next-state, grant and output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    dataS_d    = dataS_q;
    dataIn_d   = dataIn_q;
    dataIn16_d = dataIn16_q;
    dataIn32_d = dataIn32_q;
    K_d        = K_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    skp_now    = 1'b0;
    win1       = 1'b0;
    sel_size   = 2'b00;
    sel_data   = '0;
    sel_k      = 1'b0;
`ifdef SKP_INSERT_EN
    slot_d     = slot_q;
`endif

    if (enb) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (tc) begin
`ifdef SKP_INSERT_EN
      // The SKP slot itself is not counted; it only restarts the count.
      if (state_q == ST_SKP) begin
        slot_d = '0;
      end else if (slot_q == SLOT_LAST) begin
        skp_now = 1'b1;
        slot_d  = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
`endif
      if (!skp_now && (req0 || req1)) begin
        win1     = req1 && (!req0 || rr_q);
        gnt0     = !win1;
        gnt1     = win1;
        rr_d     = !win1;             // loser of this round is favoured next
        sel_size = win1 ? size1 : size0;
        sel_data = win1 ? data1 : data0;
        sel_k    = win1 ? k1 : k0;
        if (sel_size == 2'b11) begin
          sel_size = 2'b00;
        end
        state_d = ST_SEND;
        dataS_d = sel_size;
        K_d     = sel_k;
        case (sel_size)
          2'b00: begin
            dataIn_d = sel_data[7:0];
            cnt_d    = LEN_8;
          end
          2'b01: begin
            dataIn16_d = sel_data[15:0];
            cnt_d      = LEN_16;
          end
          default: begin
            dataIn32_d = sel_data;
            cnt_d      = LEN_32;
          end
        endcase
      end else begin
        state_d  = ST_COMMA;
        dataIn_d = COMMA_SYM;
`ifdef SKP_INSERT_EN
        if (skp_now) begin
          state_d  = ST_SKP;
          dataIn_d = SKP_SYM;
        end
`endif
        dataS_d = 2'b00;
        K_d     = 1'b1;
        cnt_d   = LEN_8;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_COMMA;
      cnt_q      <= LEN_8;
      rr_q       <= 1'b0;
      dataS_q    <= 2'b00;
      dataIn_q   <= COMMA_SYM;
      dataIn16_q <= '0;
      dataIn32_q <= '0;
      K_q        <= 1'b1;
`ifdef SKP_INSERT_EN
      slot_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      dataS_q    <= dataS_d;
      dataIn_q   <= dataIn_d;
      dataIn16_q <= dataIn16_d;
      dataIn32_q <= dataIn32_d;
      K_q        <= K_d;
`ifdef SKP_INSERT_EN
      slot_q     <= slot_d;
`endif
    end
  end

  assign dataS    = dataS_q;
  assign dataIn   = dataIn_q;
  assign dataIn16 = dataIn16_q;
  assign dataIn32 = dataIn32_q;
  assign K        = K_q;
  assign busy     = (state_q == ST_SEND);

endmodule
`default_nettype wire
